muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller in the execute stage, beside the single-cycle ALU.
- Sequences MULT/MULTU/DIV/DIVU over B+2 cycles and owns the architectural HI/LO registers.
- Raises busy so hazard logic can stall the pipeline.
- Takes MTHI/MTLO writes and supplies HI/LO to MFHI/MFLO.

Parameters:
- B, 32, operand/register width; must be even and at least 4.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- op1  in  B  multiplicand / dividend (rs)
- op2  in  B  multiplier / divisor (rt)
- flush  in  1  abort the in-flight operation (branch/exception squash)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  B  MTHI/MTLO data
- busy  out  1  high while in RUN or FIX
- done  out  1  one-cycle pulse when HI/LO hold a new result
- hi  out  B  HI register
- lo  out  B  LO register

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration count=0. Reset overrides every other input in the same cycle, including mid-operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge 0 latches op, absolute values of op1/op2 (signed ops only), and result sign flags; state goes to RUN with count=0.
  - start=0 holds in IDLE.
- RUN:
  - One iteration per cycle: shift-add for multiply, restoring shift-subtract for divide, using a (2B)-bit working register.
  - Count increments each cycle. After iteration B-1, state goes to FIX.
- FIX:
  - One cycle. Applies two's-complement sign correction.
  - Signed multiply: negate the 2B product if the operand signs differ.
  - Signed divide: quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
  - At the FIX edge: lo <= product[B-1:0] or quotient; hi <= product[2B-1:B] or remainder. State goes to IDLE, done=1 for exactly one cycle.
- Timing:
  - busy=1 during cycles 1..B+1 after the start edge.
  - Result and done are visible in cycle B+2.
  - A new start is accepted in the same cycle that done is high.
- Divide by zero (op2=0, signed or unsigned): no trap. lo = all ones, hi = op1 unmodified, same latency as a normal divide.
- Signed overflow (DIV of most-negative by -1): lo = most-negative, hi = 0.
- start while busy is ignored, with no queuing; the pipeline must stall on busy.
- flush:
  - In RUN or FIX, state goes to IDLE next edge. HI/LO are unchanged and done stays 0.
  - In IDLE it has no effect, and it suppresses a coincident start.
- hi_we/lo_we:
  - Honoured only in IDLE; the register updates at the next edge.
  - If start and hi_we/lo_we coincide, the write lands and the operation also starts; its result later overwrites HI/LO.
  - Ignored while busy.
- hi/lo outputs come directly from the registers, with no combinational bypass from wdata.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined:
  - Multiply leaves RUN as soon as the remaining multiplier bits are all zero, with the product aligned by a final shift. FIX still takes one cycle. Minimum multiply latency is 2 cycles from start (op2=0 or op2=1).
  - Divide latency is unchanged.
- Undefined: all operations take fixed B+2 latency.

Decomposition:
- Shared package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state encoding (ST_IDLE, ST_RUN, ST_FIX), count width localparam clog2(B)+1.
- One natural sub-module: muldiv_sign_fix, the combinational abs/negate and result-sign logic shared by the entry and FIX stages.
- The iteration datapath stays in the top module.

Test Plan:
- MULT op1=7, op2=0xFFFFFFFD (-3) -> busy for 33 cycles; in cycle 34 done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU op1=0x12345678, op2=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT 5*6, assert flush at cycle 10 -> IDLE next cycle, done never pulses, hi/lo keep their prior values. Repeat with reset at cycle 10 -> hi=lo=0.
- Second start during busy is ignored (result reflects the first operands only). Back-to-back start in the done cycle is accepted. MTLO 0xA5A5A5A5 while busy is ignored; in IDLE, lo=0xA5A5A5A5 next cycle.
- With MULDIV_EARLY_OUT_EN: MULTU 0x1234*1 -> done 2 cycles after start with lo=0x1234. DIVU latency stays 34 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation and state encodings, iteration-counter width helper,
// and small decode helpers for the op field.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Iteration counter width for a given operand width.
    function automatic int cnt_width(input int b);
        return $clog2(b) + 1;
    endfunction

    localparam int B_DEFAULT = 32;
    localparam int CNT_W     = cnt_width(B_DEFAULT);

    function automatic logic op_is_div(input logic [1:0] o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling for the multiply/divide sequencer.
// Entry side: operand magnitudes and result sign flags for signed ops.
// FIX side: two's-complement correction of the raw unsigned result
// (whole 2B product for multiply, separate quotient/remainder for divide).
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int B = 32
) (
    input  logic [1:0]     op,
    input  logic [B-1:0]   a,
    input  logic [B-1:0]   b,
    output logic [B-1:0]   a_mag,
    output logic [B-1:0]   b_mag,
    output logic           neg_res,
    output logic           neg_rem,
    input  logic           fix_div,
    input  logic           fix_neg_res,
    input  logic           fix_neg_rem,
    input  logic [2*B-1:0] raw,
    output logic [2*B-1:0] fixed
);

    logic signed [B-1:0] a_s;
    logic signed [B-1:0] b_s;
    logic                a_neg;
    logic                b_neg;

    function automatic logic [B-1:0] neg_w(input logic [B-1:0] x);
        return ~x + {{(B-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*B-1:0] neg_d(input logic [2*B-1:0] x);
        return ~x + {{(2*B-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes and result signs; unsigned ops pass through.
    always_comb begin
        a_s     = a;
        b_s     = b;
        a_neg   = op_is_signed(op) && (a_s < 0);
        b_neg   = op_is_signed(op) && (b_s < 0);
        a_mag   = a_neg ? neg_w(a) : a;
        b_mag   = b_neg ? neg_w(b) : b;
        neg_res = a_neg ^ b_neg;
        neg_rem = op_is_div(op) && a_neg;
    end

    // Final sign correction of the unsigned iteration result.
    always_comb begin
        if (!fix_div) begin
            fixed = fix_neg_res ? neg_d(raw) : raw;
        end else begin
            fixed[2*B-1:B] = fix_neg_rem ? neg_w(raw[2*B-1:B]) : raw[2*B-1:B];
            fixed[B-1:0]   = fix_neg_res ? neg_w(raw[B-1:0])   : raw[B-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// IDLE -> RUN (B iterations, one per cycle) -> FIX (sign correction,
// HI/LO write, done pulse). Multiply is shift-add, divide is restoring
// shift-subtract, both on a 2B-bit working register {upper, lower}.
// Optional macro MULDIV_EARLY_OUT_EN: multiply leaves RUN as soon as the
// remaining multiplier bits are zero (aligning the product by a final
// shift); operands with magnitude 0 or 1 go straight to FIX.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [B-1:0] op1,
    input  logic [B-1:0] op2,
    input  logic         flush,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [B-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [B-1:0] hi,
    output logic [B-1:0] lo
);

    localparam int CW = cnt_width(B);

    state_e         state;
    state_e         state_nx;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_q;
    logic [B-1:0]   dv_q;        // multiplicand or divisor magnitude
    logic [2*B-1:0] acc;         // working register
    logic           neg_res_q;
    logic           neg_rem_q;
    logic           div0_q;

    logic [B-1:0]   a_mag;
    logic [B-1:0]   b_mag;
    logic           neg_res_c;
    logic           neg_rem_c;
    logic [2*B-1:0] fixed;

    logic [B:0]     sh_hi;
    logic [B-1:0]   sub;
    logic           ge;
    logic [B:0]     sum;
    logic [2*B-1:0] acc_step;
    logic [2*B-1:0] acc_run;
    logic           early_run;
    logic           entry_early;
    logic           last_iter;
    logic           accept;

    muldiv_sign_fix #(.B(B)) u_sign_fix (
        .op          (op),
        .a           (op1),
        .b           (op2),
        .a_mag       (a_mag),
        .b_mag       (b_mag),
        .neg_res     (neg_res_c),
        .neg_rem     (neg_rem_c),
        .fix_div     (op_is_div(op_q)),
        .fix_neg_res (neg_res_q),
        .fix_neg_rem (neg_rem_q),
        .raw         (acc),
        .fixed       (fixed)
    );

    assign accept    = start && !flush;
    assign last_iter = (cnt == CW'(B - 1));

    // One multiply or divide iteration on the working register.
    always_comb begin
        sh_hi = {acc[2*B-1:B], acc[B-1]};
        ge    = (sh_hi >= {1'b0, dv_q});
        sub   = sh_hi[B-1:0] - dv_q;
        sum   = {1'b0, acc[2*B-1:B]} + (acc[0] ? {1'b0, dv_q} : {(B+1){1'b0}});
        if (op_is_div(op_q)) begin
            acc_step = ge ? {sub, acc[B-2:0], 1'b1}
                          : {sh_hi[B-1:0], acc[B-2:0], 1'b0};
        end else begin
            acc_step = {sum, acc[B-1:1]};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [CW-1:0]  sh_amt;
    logic [2*B-1:0] rem_mask;

    // Early exit when the unconsumed multiplier bits are all zero.
    always_comb begin
        sh_amt      = CW'(B - 1) - cnt;
        rem_mask    = ({{(2*B-1){1'b0}}, 1'b1} << sh_amt) - {{(2*B-1){1'b0}}, 1'b1};
        early_run   = !op_is_div(op_q) && ((acc_step & rem_mask) == '0);
        acc_run     = early_run ? (acc_step >> sh_amt) : acc_step;
        entry_early = !op_is_div(op) && (b_mag[B-1:1] == '0);
    end
`else
    // Fixed-latency build: every operation runs all B iterations.
    always_comb begin
        early_run   = 1'b0;
        acc_run     = acc_step;
        entry_early = 1'b0;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state and busy decode.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nx = entry_early ? ST_FIX : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (flush)                       state_nx = ST_IDLE;
                else if (last_iter || early_run) state_nx = ST_FIX;
            end
            ST_FIX: begin
                busy     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Control: iteration count, done pulse, HI/LO architectural writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            done <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hi_we)  hi  <= wdata;
                    if (lo_we)  lo  <= wdata;
                    if (accept) cnt <= '0;
                end
                ST_RUN: begin
                    if (!flush) cnt <= cnt + 1'b1;
                end
                ST_FIX: begin
                    if (!flush) begin
                        hi   <= fixed[2*B-1:B];
                        lo   <= div0_q ? {B{1'b1}} : fixed[B-1:0];
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: operand latch at entry, iteration update while running.
    always_ff @(posedge clk) begin
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_q      <= op;
                    neg_res_q <= neg_res_c;
                    neg_rem_q <= neg_rem_c;
                    div0_q    <= op_is_div(op) && (op2 == '0);
                    if (op_is_div(op)) begin
                        dv_q <= b_mag;
                        acc  <= {{B{1'b0}}, a_mag};
                    end else begin
                        dv_q <= a_mag;
                        if (entry_early)
                            acc <= b_mag[0] ? {{B{1'b0}}, a_mag} : '0;
                        else
                            acc <= {{B{1'b0}}, b_mag};
                    end
                end
            end
            ST_RUN:  acc <= acc_run;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO and latency are
// queued at launch and compared when done pulses. Also covers reset,
// flush, reset mid-operation, start-while-busy, MTHI/MTLO gating.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    muldiv_sequencer #(.B(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .op1   (op1),
        .op2   (op2),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

`ifdef MULDIV_EARLY_OUT_EN
    localparam int FLUSH_CYC = 2;
`else
    localparam int FLUSH_CYC = 10;
`endif

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic signed [31:0] q;
        logic signed [31:0] r;
        case (o)
            2'b00: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p;
            end
            2'b01: return {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Cycles from the start edge until done is visible.
    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [31:0] m;
        int          k;
        if (!o[1]) begin
            m = (o == 2'b00 && b[31]) ? -b : b;
            if (m <= 32'd1) return 2;
            k = 0;
            for (int i = 0; i < 32; i++) if (m[i]) k = i;
            return k + 3;
        end
`endif
        return 34;
    endfunction

    task automatic pulse_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        op1   = a;
        op2   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        exp_t x;
        x.res = e;
        x.lat = exp_lat(o, b);
        sb.push_back(x);
        pulse_start(o, a, b);
    endtask

    // Wait (bounded) for done; cyc0 = cycles already elapsed since start.
    task automatic wait_done(input int cyc0, input string tag);
        int   cyc;
        int   nb;
        exp_t x;
        cyc = cyc0;
        nb  = 0;
        while (!done && cyc < 200) begin
            if (busy) nb++;
            tick();
            cyc++;
        end
        x = sb.pop_front();
        check({tag, "_lat"}, 64'(cyc), 64'(x.lat));
        check({tag, "_busycyc"}, 64'(nb), 64'(x.lat - cyc0));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hilo"}, {hi, lo}, x.res);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input string tag);
        launch(o, a, b, e);
        wait_done(1, tag);
    endtask

    logic [63:0] prev;
    logic        seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        op1   = '0;
        op2   = '0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed results; each op starts in the previous done cycle.
        run_op(2'b00, 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, "mult_7xm3");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "multu_max");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
        run_op(2'b11, 32'h12345678, 32'h0, 64'h12345678_FFFFFFFF, "divu_by0");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_ovf");
        run_op(2'b10, 32'hFFFFFFF9, 32'h0, 64'hFFFFFFF9_FFFFFFFF, "div_neg_by0");
        run_op(2'b01, 32'h00001234, 32'h1, 64'h00000000_00001234, "multu_x1");
        run_op(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_minmin");

        // Randomised operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, model(ro, ra, rb), "rand");
        end

        // Start while busy is ignored.
        launch(2'b01, 32'd3, 32'h80000004, model(2'b01, 32'd3, 32'h80000004));
        repeat (4) tick();
        pulse_start(2'b11, 32'd100, 32'd7);
        wait_done(6, "start_busy");

        // MTLO while busy is ignored; MTLO in IDLE lands next cycle.
        prev = {hi, lo};
        launch(2'b11, 32'd1000, 32'd7, model(2'b11, 32'd1000, 32'd7));
        tick();
        tick();
        wdata = 32'hA5A5A5A5;
        lo_we = 1'b1;
        tick();
        lo_we = 1'b0;
        check("mtlo_busy", 64'(lo), prev[63:0] & 64'hFFFFFFFF);
        wait_done(4, "mtlo_op");
        lo_we = 1'b1;
        tick();
        lo_we = 1'b0;
        check("mtlo_idle", {hi, lo}, {32'd6, 32'hA5A5A5A5});

        // MTHI in IDLE, then MTLO coinciding with start.
        wdata = 32'h11111111;
        hi_we = 1'b1;
        tick();
        hi_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h11111111);
        wdata = 32'h22222222;
        lo_we = 1'b1;
        launch(2'b11, 32'd50, 32'd8, model(2'b11, 32'd50, 32'd8));
        lo_we = 1'b0;
        check("mtlo_with_start", 64'(lo), 64'h22222222);
        check("mtlo_with_start_busy", 64'(busy), 64'd1);
        wait_done(1, "mtlo_start_op");

        // Flush in IDLE suppresses a coincident start.
        flush = 1'b1;
        pulse_start(2'b00, 32'd5, 32'd6);
        flush = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);

        // Flush mid-operation: back to IDLE, no done, HI/LO kept.
        prev = {hi, lo};
        pulse_start(2'b00, 32'd5, 32'd6);
        for (int c = 1; c < FLUSH_CYC; c++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("flush_done", 64'(seen), 64'd0);
        check("flush_hilo", {hi, lo}, prev);

        // Reset mid-operation clears HI/LO.
        pulse_start(2'b00, 32'd5, 32'd6);
        for (int c = 1; c < FLUSH_CYC; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_hilo", {hi, lo}, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) seen = 1'b1;
            tick();
        end
        check("rstmid_done", 64'(seen), 64'd0);
        check("rstmid_hilo_after", {hi, lo}, 64'd0);

        // Normal operation after reset.
        run_op(2'b00, 32'd5, 32'd6, 64'd30, "mult_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
